// File: rtl/sdf_twiddle_mult_pkg.sv
// Shared widths and elaboration-time helpers for the SDF twiddle multiplier stage.
// DATA_IN_WIDTH mirrors the codebase-wide sample width; TW_WIDTH_DEFAULT is the shared twiddle width.
package sdf_twiddle_mult_pkg;

    localparam int  DATA_IN_WIDTH    = 16;
    localparam int  TW_WIDTH_DEFAULT = 16;
    localparam real TW_PI            = 3.14159265358979323846;

    // Round half away from zero; only used to build the twiddle table.
    function automatic int round_real(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end else begin
            return -$rtoi(0.5 - x);
        end
    endfunction

endpackage

// File: rtl/sdf_twiddle_rom.sv
// Twiddle ROM: FFT_N/2 entries of W_N^k = c + j*d with d = -sin, scaled so 1.0 = 2^(TW_WIDTH-2).
// Contents are computed at elaboration; the read is registered (one cycle).
module sdf_twiddle_rom
    import sdf_twiddle_mult_pkg::*;
#(
    parameter int FFT_N    = 64,
    parameter int TW_WIDTH = TW_WIDTH_DEFAULT
) (
    input  logic                                clk,
    input  logic [$clog2(FFT_N/2)-1:0]          addr,
    output logic signed [TW_WIDTH-1:0]          tw_c,
    output logic signed [TW_WIDTH-1:0]          tw_d
);

    localparam int ROM_DEPTH = FFT_N / 2;
    localparam int TW_ONE    = 2 ** (TW_WIDTH - 2);

    function automatic logic signed [TW_WIDTH-1:0] tw_cos(input int k);
        real ang;
        ang = 2.0 * TW_PI * real'(k) / real'(FFT_N);
        return TW_WIDTH'(round_real($cos(ang) * real'(TW_ONE)));
    endfunction

    function automatic logic signed [TW_WIDTH-1:0] tw_nsin(input int k);
        real ang;
        ang = 2.0 * TW_PI * real'(k) / real'(FFT_N);
        return TW_WIDTH'(-round_real($sin(ang) * real'(TW_ONE)));
    endfunction

    logic signed [TW_WIDTH-1:0] c_tab_s [ROM_DEPTH];
    logic signed [TW_WIDTH-1:0] d_tab_s [ROM_DEPTH];

    for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_tab
        assign c_tab_s[i] = tw_cos(i);
        assign d_tab_s[i] = tw_nsin(i);
    end

    // Registered table read.
    always_ff @(posedge clk) begin
        tw_c <= c_tab_s[addr];
        tw_d <= d_tab_s[addr];
    end

endmodule

// File: rtl/sdf_twiddle_mult.sv
// Twiddle multiplier following a radix-2 SDF butterfly: tracks position m in each 2*D block
// and multiplies every sample by W_N^k through a 3-stage rounding/saturating complex multiplier.
module sdf_twiddle_mult
    import sdf_twiddle_mult_pkg::*;
#(
    parameter int FFT_N       = 64,
    parameter int DELAY_DEPTH = 8,
    parameter int TW_WIDTH    = TW_WIDTH_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             di_en,
    input  logic signed [DATA_IN_WIDTH-1:0]  di_re,
    input  logic signed [DATA_IN_WIDTH-1:0]  di_im,
    output logic                             do_en,
    output logic signed [DATA_IN_WIDTH-1:0]  do_re,
    output logic signed [DATA_IN_WIDTH-1:0]  do_im
);

    localparam int DW = DATA_IN_WIDTH;
    localparam int MW = $clog2(2 * DELAY_DEPTH);
    localparam int KW = $clog2(FFT_N / 2);
    localparam int S  = $clog2(FFT_N / (2 * DELAY_DEPTH));
    localparam int PW = DW + TW_WIDTH;
    localparam int SW = PW + 1;

    localparam logic signed [SW-1:0] RND_OFS = SW'(2 ** (TW_WIDTH - 3));
    localparam logic signed [SW-1:0] SAT_HI  = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO  = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] OUT_HI  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_LO  = {1'b1, {(DW-1){1'b0}}};

    // Round-then-saturate of an already shifted sum.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] x);
        if (x > SAT_HI) begin
            return OUT_HI;
        end else if (x < SAT_LO) begin
            return OUT_LO;
        end else begin
            return x[DW-1:0];
        end
    endfunction

    logic [MW-1:0]           m_r;
    logic [KW-1:0]           m_off_s;
    logic [KW-1:0]           k_s;

    logic                    v1_r;
    logic                    v2_r;
    logic signed [DW-1:0]    a_r;
    logic signed [DW-1:0]    b_r;
    logic signed [TW_WIDTH-1:0] c_s;
    logic signed [TW_WIDTH-1:0] d_s;

    logic signed [PW-1:0]    ac_r;
    logic signed [PW-1:0]    bd_r;
    logic signed [PW-1:0]    ad_r;
    logic signed [PW-1:0]    bc_r;

    logic signed [SW-1:0]    re_sum_s;
    logic signed [SW-1:0]    im_sum_s;
    logic signed [SW-1:0]    re_shr_s;
    logic signed [SW-1:0]    im_shr_s;

    // Sample position counter; reset wins over a coincident di_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_r <= '0;
        end else if (di_en) begin
            m_r <= m_r + MW'(1);
        end else begin
            m_r <= m_r;
        end
    end

    // Twiddle index: first half of the block is the sum path (k = 0).
    always_comb begin
        m_off_s = KW'(m_r - MW'(DELAY_DEPTH));
        if (m_r < MW'(DELAY_DEPTH)) begin
            k_s = '0;
        end else begin
            k_s = m_off_s << S;
        end
    end

    sdf_twiddle_rom #(
        .FFT_N    (FFT_N),
        .TW_WIDTH (TW_WIDTH)
    ) u_rom (
        .clk  (clk),
        .addr (k_s),
        .tw_c (c_s),
        .tw_d (d_s)
    );

    // P1: capture the sample alongside the ROM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
        end else begin
            v1_r <= di_en;
            if (di_en) begin
                a_r <= di_re;
                b_r <= di_im;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
            end
        end
    end

    // P2: four full-width partial products.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2_r <= 1'b0;
            ac_r <= '0;
            bd_r <= '0;
            ad_r <= '0;
            bc_r <= '0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                ac_r <= PW'(a_r) * PW'(c_s);
                bd_r <= PW'(b_r) * PW'(d_s);
                ad_r <= PW'(a_r) * PW'(d_s);
                bc_r <= PW'(b_r) * PW'(c_s);
            end else begin
                ac_r <= ac_r;
                bd_r <= bd_r;
                ad_r <= ad_r;
                bc_r <= bc_r;
            end
        end
    end

    // P3 combine: one guard bit keeps the sums exact before rounding.
    always_comb begin
        re_sum_s = SW'(ac_r) - SW'(bd_r);
        im_sum_s = SW'(ad_r) + SW'(bc_r);
        re_shr_s = (re_sum_s + RND_OFS) >>> (TW_WIDTH - 2);
        im_shr_s = (im_sum_s + RND_OFS) >>> (TW_WIDTH - 2);
    end

    // P3 register: outputs hold their last value between valid cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end else begin
            do_en <= v2_r;
            if (v2_r) begin
                do_re <= sat_dw(re_shr_s);
                do_im <= sat_dw(im_shr_s);
            end else begin
                do_re <= do_re;
                do_im <= do_im;
            end
        end
    end

endmodule

// File: tb/tb_sdf_twiddle_mult.sv
// Self-checking bench for sdf_twiddle_mult (FFT_N=64, D=8, DW=TW=16) against a cycle-scheduled
// reference model built from the twiddle formula and plain integer arithmetic.
module tb_sdf_twiddle_mult;

    localparam int DW = sdf_twiddle_mult_pkg::DATA_IN_WIDTH;
    localparam int NC = 4096;

    logic                 clk;
    logic                 reset;
    logic                 di_en;
    logic signed [DW-1:0] di_re;
    logic signed [DW-1:0] di_im;
    logic                 do_en;
    logic signed [DW-1:0] do_re;
    logic signed [DW-1:0] do_im;

    sdf_twiddle_mult #(
        .FFT_N       (64),
        .DELAY_DEPTH (8),
        .TW_WIDTH    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    always #5 clk = ~clk;

    int  checks;
    int  errors;
    int  cyc;
    int  m_mod;
    longint last_re;
    longint last_im;
    bit     exp_v  [NC];
    longint exp_re [NC];
    longint exp_im [NC];
    longint cap_re [$];
    longint cap_im [$];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, got, want);
        end
    endtask

    function automatic longint rnd(input real x);
        return longint'($rtoi($floor(x + 0.5)));
    endfunction

    // Reference: W_64^k applied with round-half-up at 2^-14 and 16-bit saturation.
    task automatic model(input int m, input longint a, input longint b, output longint ore, output longint oim);
        int  k;
        real ang;
        longint c, d, re, im;
        k   = (m < 8) ? 0 : (m - 8) * 4;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / 64.0;
        c   = rnd($cos(ang) * 16384.0);
        d   = -rnd($sin(ang) * 16384.0);
        re  = (a * c - b * d + 8192) >>> 14;
        im  = (a * d + b * c + 8192) >>> 14;
        ore = (re > 32767) ? 32767 : ((re < -32768) ? -32768 : re);
        oim = (im > 32767) ? 32767 : ((im < -32768) ? -32768 : im);
    endtask

    task automatic step(input bit rst, input bit en, input int re, input int im);
        longint ore, oim;
        reset = rst;
        di_en = en;
        di_re = DW'(re);
        di_im = DW'(im);
        if (rst) begin
            for (int t = cyc + 1; t < NC; t++) exp_v[t] = 1'b0;
            m_mod   = 0;
            last_re = 0;
            last_im = 0;
        end else if (en) begin
            model(m_mod, longint'(di_re), longint'(di_im), ore, oim);
            exp_v[cyc + 3]  = 1'b1;
            exp_re[cyc + 3] = ore;
            exp_im[cyc + 3] = oim;
            m_mod = (m_mod + 1) % 16;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (exp_v[cyc]) begin
            last_re = exp_re[cyc];
            last_im = exp_im[cyc];
        end
        chk("do_en", 64'(do_en), 64'(exp_v[cyc]));
        chk("do_re", 64'(do_re), last_re);
        chk("do_im", 64'(do_im), last_im);
        if (do_en === 1'b1) begin
            cap_re.push_back(longint'(do_re));
            cap_im.push_back(longint'(do_im));
        end
    endtask

    task automatic chk_cap(input string tag, input int idx, input longint wre, input longint wim);
        if (idx < cap_re.size()) begin
            chk({tag, "_re"}, cap_re[idx], wre);
            chk({tag, "_im"}, cap_im[idx], wim);
        end else begin
            chk({tag, "_present"}, 64'(cap_re.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; di_en = 1'b0; di_re = '0; di_im = '0;
        checks = 0; errors = 0; cyc = 0; m_mod = 0; last_re = 0; last_im = 0;
        for (int t = 0; t < NC; t++) exp_v[t] = 1'b0;
        @(negedge clk);

        // Reset held 5 cycles with di_en toggling, then 3 idle cycles.
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2), int'($urandom_range(0, 65535)) - 32768, 7);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);

        // Continuous (1000,0) for 17 samples covers the whole block and the wrap.
        cap_re.delete(); cap_im.delete();
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1000, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
        chk_cap("m0", 0, 1000, 0);
        chk_cap("m8", 8, 1000, 0);
        chk_cap("m10", 10, 707, -707);
        chk_cap("m12", 12, 0, -1000);
        chk_cap("m15", 15, -924, -383);
        chk_cap("wrap", 16, 1000, 0);

        // Saturation at m=10.
        step(1'b1, 1'b0, 0, 0);
        cap_re.delete(); cap_im.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
        step(1'b0, 1'b1, 32767, 32767);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
        chk_cap("sat", 10, 32767, 0);

        // Gap of 3 idle cycles between m=3 and m=4.
        step(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1000, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
        for (int i = 4; i < 16; i++) step(1'b0, 1'b1, 1000, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);

        // Mid-frame reset coinciding with di_en; next sample must be m=0.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1000, 0);
        step(1'b1, 1'b1, 1234, 4321);
        cap_re.delete(); cap_im.delete();
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1000, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
        chk_cap("post_rst_m0", 0, 1000, 0);
        chk_cap("post_rst_m10", 10, 707, -707);

        // Random traffic with gaps and occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdf_twiddle_mult.md
# sdf_twiddle_mult

Twiddle-factor multiplier stage placed directly downstream of an `SdfUnit2` radix-2 SDF butterfly. It consumes the butterfly's output stream and tracks the sample position within each 2·DELAY_DEPTH block. Each sample is multiplied by the stage's twiddle factor W_FFT_N^k, using a 3-cycle pipelined complex multiplier with rounding and saturation. The output feeds the next `SdfUnit2` stage.

## Interface
- FFT_N, 64: total FFT points; power of two, ≥ 4.
- DELAY_DEPTH, 8: delay depth D of the preceding butterfly; power of two, ≤ FFT_N/2.
- TW_WIDTH, 16: signed twiddle width; 1.0 is represented as 2^(TW_WIDTH-2).
- clk  input  1  master clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- di_en  input  1  input sample valid.
- di_re  input  `DATA_IN_WIDTH  input real part, signed.
- di_im  input  `DATA_IN_WIDTH  input imaginary part, signed.
- do_en  output  1  output sample valid.
- do_re  output  `DATA_IN_WIDTH  output real part, signed.
- do_im  output  `DATA_IN_WIDTH  output imaginary part, signed.

## Operation
- DW = `DATA_IN_WIDTH` (from define.v). S = log2(FFT_N/(2·D)).
- **Sample counter m** (log2(2D) bits):
  - Increments only on cycles with di_en=1.
  - Wraps from 2D-1 to 0.
  - Holds during di_en=0 gaps.
- **Twiddle index k:**
  - m < D: k = 0 (sum path, W = 1).
  - m ≥ D: k = (m-D) << S.
  - k < FFT_N/2 always.
- **Twiddle ROM:** FFT_N/2 entries.
  - c[k] = round(cos(2πk/FFT_N)·2^(TW-2)).
  - d[k] = -round(sin(2πk/FFT_N)·2^(TW-2)).
- **Complex multiply:**
  - re = a·c − b·d; im = a·d + b·c, where a = di_re, b = di_im.
  - Products are full-width DW+TW. Sums are DW+TW+1 bits.
- **Scaling:** add 2^(TW-3), then arithmetic shift right by TW-2.
  - Saturate to [−2^(DW-1), 2^(DW-1)−1].
  - W = 1 therefore passes data unchanged.
- **Uniform path:** all samples go through the multiplier, including k = 0; there is no bypass path.
- **Reset:**
  - m = 0, all pipeline valid bits = 0.
  - do_en = 0, do_re = 0, do_im = 0.
  - Samples in flight when reset asserts are discarded, not flushed out.
- **Reset mid-frame:** the first di_en sample after reset deassert uses m = 0.
- **Simultaneous reset and di_en:** reset wins; the sample is dropped and not counted.
- No backpressure. The downstream stage accepts every do_en cycle.

## Timing
- Latency is exactly 3 cycles, di_en → do_en, with one output per input.
- Pipeline stages:
  - P1: register a, b, valid, and ROM read of c, d at index k.
  - P2: four registered products.
  - P3: add/subtract, round, saturate; register the outputs.
- do_en is high for one cycle per accepted input, in order. Input gaps are preserved in the output.
- While do_en = 0, do_re and do_im hold their last values.
- Full throughput: one sample per cycle with di_en held high continuously.

## Structure
- define.v holds DATA_IN_WIDTH (existing) and the shared TW_WIDTH default.
- Sub-module `sdf_twiddle_rom`:
  - Parameters FFT_N and TW_WIDTH.
  - Registered output, 1-cycle read.
  - Contents computed at elaboration by a function using $cos and $sin.
- Counter, index computation and multiplier pipeline live in `sdf_twiddle_mult`.

## Test plan
Configuration for all scenarios: DW=16, TW=16, FFT_N=64, D=8, so 1.0 = 16384.
1. **Reset:** hold reset for 5 cycles with di_en toggling → do_en=0, do_re=0, do_im=0 throughout, and for 3 cycles after release.
2. **Continuous constant input:** di_en=1, input (1000,0) for 16 samples → outputs start 3 cycles after the first sample:
   - m = 0..8: (1000, 0).
   - m = 10, k=8, W=11585−j11585: (707, −707).
   - m = 12, k=16, W=−j: (0, −1000).
   - m = 15, k=28: (−924, −383).
3. **Saturation:** input (32767, 32767) at m=10 → re = 46339 before clamping, output (32767, 0).
4. **Input gaps:** 3 idle cycles inserted between samples m=3 and m=4 → twiddle sequence unchanged, and do_en shows the same 3-cycle gap.
5. **Wrap:** 17 consecutive samples of (1000,0) → sample 17 has m=0 and output (1000, 0).
6. **Mid-frame reset:** reset for 1 cycle after 5 samples (2 still in the pipeline) → the in-flight outputs never appear, and the next sample is processed as m=0.
